// File: rtl/apb_cmd_sequencer.sv
// apb_cmd_sequencer
//   Sits in front of apb_master. Requester commands are queued in a command
//   FIFO and handed to the master one at a time. Each completion (or a
//   synthetic error after TIMEOUT cycles) is queued in a response FIFO that the
//   requester drains with valid/ready.
//
// Ports
//   pclk, preset           clock, synchronous active-high reset
//   i_req_cmd/i_req_valid  requester command {pwrite, pstrb, pwdata, paddr}
//   o_req_ready            command FIFO has room
//   o_rsp_data/o_rsp_valid head of response FIFO {pslverr, prdata}
//   i_rsp_ready            requester consumes the head response
//   o_cmd/o_valid          command to apb_master, one-cycle valid pulse
//   i_resp/i_ready         completion from apb_master, one-cycle pulse
//   o_busy                 a command is in flight
//   o_timeout              sticky timeout flag, cleared only by reset
module apb_cmd_sequencer #(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int SW      = DW / 8,
   parameter int CW      = 1 + SW + DW + AW,
   parameter int RW      = 1 + DW,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic          pclk,
   input  logic          preset,
   input  logic [CW-1:0] i_req_cmd,
   input  logic          i_req_valid,
   output logic          o_req_ready,
   output logic [RW-1:0] o_rsp_data,
   output logic          o_rsp_valid,
   input  logic          i_rsp_ready,
   output logic [CW-1:0] o_cmd,
   output logic          o_valid,
   input  logic [RW-1:0] i_resp,
   input  logic          i_ready,
   output logic          o_busy,
   output logic          o_timeout
);

   localparam int PW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [PW:0]   PTR_ONE  = (PW + 1)'(1'b1);
   localparam logic [TW-1:0] CNT_ONE  = TW'(1'b1);
   localparam logic [TW-1:0] CNT_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } state_t;

   state_t        state_r;
   logic [CW-1:0] cmd_r;
   logic          valid_r;
   logic          busy_r;
   logic          timeout_r;
   logic [TW-1:0] cnt_r;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [CW-1:0] cmd_mem_r [DEPTH];
   logic [PW:0]   cmd_wr_r, cmd_rd_r;
   logic [RW-1:0] rsp_mem_r [DEPTH];
   logic [PW:0]   rsp_wr_r, rsp_rd_r;

   logic          cmd_empty_s, cmd_full_s, cmd_push_s, cmd_pop_s;
   logic          rsp_empty_s, rsp_full_s, rsp_pop_s, rsp_push_s;
   logic [RW-1:0] rsp_push_data_s;

   assign cmd_empty_s = (cmd_wr_r == cmd_rd_r);
   assign cmd_full_s  = (cmd_wr_r[PW] != cmd_rd_r[PW]) &&
                        (cmd_wr_r[PW-1:0] == cmd_rd_r[PW-1:0]);
   assign rsp_empty_s = (rsp_wr_r == rsp_rd_r);
   assign rsp_full_s  = (rsp_wr_r[PW] != rsp_rd_r[PW]) &&
                        (rsp_wr_r[PW-1:0] == rsp_rd_r[PW-1:0]);

   // Ready is held low for the whole reset window, then follows FIFO occupancy.
   assign o_req_ready = !preset && !cmd_full_s;
   assign cmd_push_s  = i_req_valid && o_req_ready;
   // Issuing only when the response FIFO has room reserves the completion slot.
   assign cmd_pop_s   = (state_r == IDLE) && !cmd_empty_s && !rsp_full_s;

   assign o_rsp_valid = !rsp_empty_s;
   assign o_rsp_data  = rsp_empty_s ? {RW{1'b0}} : rsp_mem_r[rsp_rd_r[PW-1:0]];
   assign rsp_pop_s   = !rsp_empty_s && i_rsp_ready;

   assign o_cmd     = cmd_r;
   assign o_valid   = valid_r;
   assign o_busy    = busy_r;
   assign o_timeout = timeout_r;

   // Select what, if anything, enters the response FIFO this cycle.
   always_comb begin
      rsp_push_s      = 1'b0;
      rsp_push_data_s = {RW{1'b0}};
      case (state_r)
         ISSUE: begin
            if (i_ready) begin
               rsp_push_s      = 1'b1;
               rsp_push_data_s = i_resp;
            end else begin
               rsp_push_s      = 1'b0;
            end
         end
         WAIT: begin
            if (i_ready) begin
               rsp_push_s      = 1'b1;
               rsp_push_data_s = i_resp;
            end else if (cnt_r == CNT_LAST) begin
               rsp_push_s      = 1'b1;
               rsp_push_data_s = {1'b1, {DW{1'b0}}};
            end else begin
               rsp_push_s      = 1'b0;
            end
         end
         default: begin
            rsp_push_s      = 1'b0;
         end
      endcase
   end

   // Command FIFO storage and pointers.
   always_ff @(posedge pclk) begin
      if (preset) begin
         cmd_wr_r <= {(PW + 1){1'b0}};
         cmd_rd_r <= {(PW + 1){1'b0}};
      end else begin
         if (cmd_push_s) begin
            cmd_mem_r[cmd_wr_r[PW-1:0]] <= i_req_cmd;
            cmd_wr_r <= cmd_wr_r + PTR_ONE;
         end
         if (cmd_pop_s) begin
            cmd_rd_r <= cmd_rd_r + PTR_ONE;
         end
      end
   end

   // Response FIFO storage and pointers.
   always_ff @(posedge pclk) begin
      if (preset) begin
         rsp_wr_r <= {(PW + 1){1'b0}};
         rsp_rd_r <= {(PW + 1){1'b0}};
      end else begin
         if (rsp_push_s) begin
            rsp_mem_r[rsp_wr_r[PW-1:0]] <= rsp_push_data_s;
            rsp_wr_r <= rsp_wr_r + PTR_ONE;
         end
         if (rsp_pop_s) begin
            rsp_rd_r <= rsp_rd_r + PTR_ONE;
         end
      end
   end

   // Issue/wait sequencer. cnt_r counts cycles since the ISSUE cycle, so the
   // synthetic error is pushed TIMEOUT-1 cycles after ISSUE and becomes
   // visible TIMEOUT cycles after it.
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_r   <= IDLE;
         cmd_r     <= {CW{1'b0}};
         valid_r   <= 1'b0;
         busy_r    <= 1'b0;
         timeout_r <= 1'b0;
         cnt_r     <= {TW{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               cnt_r <= {TW{1'b0}};
               if (cmd_pop_s) begin
                  cmd_r   <= cmd_mem_r[cmd_rd_r[PW-1:0]];
                  valid_r <= 1'b1;
                  busy_r  <= 1'b1;
                  state_r <= ISSUE;
               end else begin
                  valid_r <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
            ISSUE: begin
               valid_r <= 1'b0;
               if (i_ready) begin
                  cnt_r   <= {TW{1'b0}};
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else begin
                  cnt_r   <= cnt_r + CNT_ONE;
                  state_r <= WAIT;
               end
            end
            WAIT: begin
               valid_r <= 1'b0;
               if (i_ready) begin
                  cnt_r   <= {TW{1'b0}};
                  busy_r  <= 1'b0;
                  state_r <= IDLE;
               end else if (cnt_r == CNT_LAST) begin
                  cnt_r     <= {TW{1'b0}};
                  busy_r    <= 1'b0;
                  timeout_r <= 1'b1;
                  state_r   <= IDLE;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            default: begin
               valid_r <= 1'b0;
               busy_r  <= 1'b0;
               cnt_r   <= {TW{1'b0}};
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/apb_cmd_sequencer.md
Name: apb_cmd_sequencer

Overview:
- Upstream stage of apb_master. Buffers bus commands from a requester (CPU model, test sequencer or DMA) in a command FIFO.
- Issues commands to apb_master one at a time on its i_cmd/i_valid port and waits for each completion on o_resp/o_ready.
- Returns each response to the requester through a response FIFO with valid/ready backpressure.
- Guards every transfer with a timeout so a hung slave cannot stall the requester forever.

Parameters:
- DW, 32, data width
- AW, 5, address width
- SW, DW/8, strobe width
- CW, 1+SW+DW+AW, command width; layout {pwrite, pstrb, pwdata, paddr}
- RW, 1+DW, response width; layout {pslverr, prdata}
- DEPTH, 4, entries in each FIFO; power of two, minimum 2
- TIMEOUT, 64, cycles allowed in WAIT before a synthetic error response; minimum 2

Ports:
- pclk  in  1  clock
- preset  in  1  reset
- i_req_cmd  in  CW  requester command
- i_req_valid  in  1  requester command valid
- o_req_ready  out  1  command FIFO can accept
- o_rsp_data  out  RW  response at head of response FIFO
- o_rsp_valid  out  1  response FIFO not empty
- i_rsp_ready  in  1  requester consumes response
- o_cmd  out  CW  to apb_master i_cmd
- o_valid  out  1  to apb_master i_valid; one-cycle pulse per command
- i_resp  in  RW  from apb_master o_resp
- i_ready  in  1  from apb_master o_ready; one-cycle completion pulse
- o_busy  out  1  a command is in flight (state != IDLE)
- o_timeout  out  1  sticky: a timeout has occurred

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Clock port is pclk, reset port is preset.
- All registers update on the rising edge of pclk.
- While preset=1:
  - both FIFOs are emptied and FSM = IDLE
  - o_valid=0, o_cmd=0, o_busy=0, o_timeout=0
  - o_rsp_valid=0, o_rsp_data=0, o_req_ready=0
- After reset deasserts, o_req_ready=1 from the first cycle.
- Reset mid-operation: the in-flight command and all queued commands/responses are discarded. No response is produced for them.
- Command FIFO:
  - push when i_req_valid && o_req_ready
  - o_req_ready = !cmd_full, from registered state
  - a pop and a push in the same cycle are both honoured; count is unchanged
- Response FIFO:
  - pop when o_rsp_valid && i_rsp_ready
  - o_rsp_data is the head entry
  - push and pop in the same cycle are both honoured
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when cmd FIFO is not empty AND response FIFO is not full. This reserves a slot, so a completion can never be dropped. At that edge, pop the cmd head into o_cmd.
  - ISSUE: o_valid=1 for exactly this one cycle. Next state is WAIT.
  - WAIT: o_valid=0 and o_cmd held stable. The timeout counter increments each cycle.
  - i_ready=1 in ISSUE or WAIT pushes i_resp into the response FIFO, clears the counter, and goes to IDLE.
  - Counter reaching TIMEOUT-1 in WAIT without i_ready:
    - push the synthetic response {1'b1, DW'h0}
    - set o_timeout (cleared only by reset)
    - go to IDLE
- i_ready while in IDLE (late completion after a timeout) is ignored; nothing is pushed.
- Timing:
  - o_valid rises two cycles after the edge that accepts a request into an empty FIFO with an idle FSM.
  - o_rsp_valid rises the cycle after the edge at which i_ready is sampled.
  - Back-to-back commands: the next ISSUE begins at the earliest one cycle after the completion edge.
- Ordering: responses are delivered in strict command order.
- o_busy=1 in ISSUE and WAIT.

Test Plan:
- Write then read: request write {1, 4'hF, 32'hA5A5A5A5, 5'h00}, then read {0, 4'h0, 32'h0, 5'h00}; mock master completes after 2 cycles with read data 32'hA5A5A5A5.
  -> o_valid pulses exactly once per command with o_cmd equal to the request.
  -> responses pop in order as {0, x} then {0, 32'hA5A5A5A5}.
- Command backpressure: i_rsp_ready=0 and mock master never completes; push 6 requests.
  -> o_req_ready drops after the cmd FIFO holds 4; exactly one o_valid pulse occurs.
  -> no further pulses until a completion arrives.
- Response backpressure: i_rsp_ready=0 and master completes in 2 cycles; push 8 commands.
  -> response FIFO fills to 4; FSM stays IDLE with o_valid=0.
  -> raising i_rsp_ready for one cycle frees one slot and causes exactly one new ISSUE.
- Timeout: master never asserts i_ready.
  -> exactly TIMEOUT=64 cycles after the ISSUE cycle, response {1, 32'h0} appears and o_timeout=1.
  -> a later stray i_ready pulse pushes nothing.
- Reset mid-flight: assert preset during WAIT with 3 commands queued.
  -> next cycle: o_busy=0, o_rsp_valid=0, o_req_ready=0.
  -> after release: o_req_ready=1 and no stale response ever appears.
- Simultaneous push/pop: cmd FIFO holds 3; a request is pushed in the same cycle IDLE pops.
  -> count remains 3 and the command order is preserved on o_cmd.
